// File: rtl/ines_stream_loader.sv
// ines_stream_loader: parses a streamed iNES 1.0 / NES 2.0 cartridge image and writes the optional
// trainer, PRG and CHR payload to memory through a level-request / one-cycle-ack handshake.
//   clk_i, reset_i            : clock, synchronous active-high reset (restarts the parser)
//   invert_mirror_i           : OSD mirroring invert, applied combinationally
//   in_valid_i, in_data_i     : one-cycle byte strobe from the HPS stream
//   in_wait_o                 : back-pressure; the HPS must not strobe while high
//   mem_addr_o/data_o/write_o : write request, held until mem_ack_i
//   mem_ack_i                 : one-cycle write completion
//   mapper_o .. battery_o     : cartridge fields decoded from the header
//   done_o, error_o, err_code_o : sticky completion / first-fault status
module ines_stream_loader #(
  parameter int unsigned       ADDR_W       = 22,
  parameter bit                TRAINER_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] TRAINER_BASE = ADDR_W'(22'h3FFE00),
  parameter bit                NES20_EN     = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              invert_mirror_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_wait_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  output logic [11:0]       mapper_o,
  output logic [3:0]        submapper_o,
  output logic [11:0]       prg_units_o,
  output logic [11:0]       chr_units_o,
  output logic              mirroring_o,
  output logic              four_screen_o,
  output logic              battery_o,
  output logic              done_o,
  output logic              error_o,
  output logic [2:0]        err_code_o
);

  typedef enum logic [2:0] {
    StHeader, StCheck, StTrainer, StPrg, StChr, StDone, StError
  } state_e;

  localparam logic [2:0] ErrMagic   = 3'd1;
  localparam logic [2:0] ErrTrainer = 3'd2;
  localparam logic [2:0] ErrSize    = 3'd3;
  localparam logic [2:0] ErrRegion  = 3'd4;
  localparam logic [2:0] ErrOverrun = 3'd5;

  localparam logic [31:0]       RegionBytes  = 32'd1 << (ADDR_W - 1);
  localparam logic [ADDR_W-1:0] ChrBase      = ADDR_W'(RegionBytes);
  localparam logic [ADDR_W-1:0] TrainerBytes = ADDR_W'(512);
  localparam logic [ADDR_W-1:0] One          = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [3:0]        hcnt_q, hcnt_d;
  logic [7:0]        hdr_q [16];
  logic              hdr_we;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d, ovr_q, ovr_d;
  logic [2:0]        err_q, err_d;
  logic [11:0]       mapper_q, mapper_d, prg_q, prg_d, chr_q, chr_d;
  logic [3:0]        submapper_q, submapper_d;
  logic              mir_q, mir_d, four_q, four_d, batt_q, batt_d;

  // Header decode, consumed only in StCheck.
  logic        nes20, dirty, magic_ok, trainer, size_bad, region_bad;
  logic [11:0] prg_units, chr_units, mapper_c;
  logic [3:0]  submapper_c;
  logic [31:0] prg_bytes, chr_bytes;
  logic        unused_hdr;

  assign unused_hdr = ^hdr_q[7][1:0];

  always_comb begin
    nes20 = NES20_EN && (hdr_q[7][3:2] == 2'b10);
    dirty = 1'b0;
    for (int i = 8; i < 16; i++) dirty = dirty | (hdr_q[i] != 8'h00);
    // Old dumpers left junk in bytes 8..15; drop the high mapper nibble in that case.
    dirty       = dirty & ~nes20;
    magic_ok    = (hdr_q[0] == 8'h4E) && (hdr_q[1] == 8'h45) &&
                  (hdr_q[2] == 8'h53) && (hdr_q[3] == 8'h1A);
    trainer     = hdr_q[6][2];
    prg_units   = {nes20 ? hdr_q[9][3:0] : 4'h0, hdr_q[4]};
    chr_units   = {nes20 ? hdr_q[9][7:4] : 4'h0, hdr_q[5]};
    mapper_c    = {nes20 ? hdr_q[8][3:0] : 4'h0, dirty ? 4'h0 : hdr_q[7][7:4], hdr_q[6][7:4]};
    submapper_c = nes20 ? hdr_q[8][7:4] : 4'h0;
    // MSB nibble 0xF selects the exponent-multiplier size form, which is not supported.
    size_bad    = (prg_units[11:8] == 4'hF) || (chr_units[11:8] == 4'hF) || (prg_units == 12'd0);
    prg_bytes   = {6'd0, prg_units, 14'd0};
    chr_bytes   = {7'd0, chr_units, 13'd0};
    region_bad  = (prg_bytes > RegionBytes) || (chr_bytes > RegionBytes);
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    hdr_we      = 1'b0;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = wr_q;
    ovr_d       = ovr_q;
    err_d       = err_q;
    mapper_d    = mapper_q;
    submapper_d = submapper_q;
    prg_d       = prg_q;
    chr_d       = chr_q;
    mir_d       = mir_q;
    four_d      = four_q;
    batt_d      = batt_q;
    unique case (state_q)
      StHeader: begin
        if (in_valid_i) begin
          hdr_we = 1'b1;
          hcnt_d = hcnt_q + 4'd1;
          if (hcnt_q == 4'd15) state_d = StCheck;
        end
      end
      StCheck: begin
        mapper_d    = mapper_c;
        submapper_d = submapper_c;
        prg_d       = prg_units;
        chr_d       = chr_units;
        mir_d       = hdr_q[6][0];
        four_d      = hdr_q[6][3];
        batt_d      = hdr_q[6][1];
        if (!magic_ok) begin
          state_d = StError;
          err_d   = ErrMagic;
        end else if (trainer && !TRAINER_EN) begin
          state_d = StError;
          err_d   = ErrTrainer;
        end else if (size_bad) begin
          state_d = StError;
          err_d   = ErrSize;
        end else if (region_bad) begin
          state_d = StError;
          err_d   = ErrRegion;
        end else if (in_valid_i) begin
          // in_wait_o is high during this cycle, so a strobe here is an overrun.
          state_d = StError;
          err_d   = ErrOverrun;
        end else if (trainer) begin
          state_d = StTrainer;
          cnt_d   = TrainerBytes;
          addr_d  = TRAINER_BASE;
        end else begin
          state_d = StPrg;
          cnt_d   = ADDR_W'(prg_bytes);
          addr_d  = '0;
        end
      end
      StTrainer, StPrg, StChr: begin
        if (!wr_q) begin
          if (in_valid_i) begin
            wr_d   = 1'b1;
            data_d = in_data_i;
          end
        end else if (mem_ack_i) begin
          wr_d   = 1'b0;
          ovr_d  = 1'b0;
          cnt_d  = cnt_q - One;
          addr_d = addr_q + One;
          if (ovr_q || in_valid_i) begin
            state_d = StError;
            err_d   = ErrOverrun;
          end else if (cnt_q == One) begin
            // Last byte of the section: move on without waiting for another strobe.
            if (state_q == StTrainer) begin
              state_d = StPrg;
              cnt_d   = ADDR_W'({prg_q, 14'd0});
              addr_d  = '0;
            end else if (state_q == StPrg && chr_q != 12'd0) begin
              state_d = StChr;
              cnt_d   = ADDR_W'({chr_q, 13'd0});
              addr_d  = ChrBase;
            end else begin
              state_d = StDone;
            end
          end
        end else if (in_valid_i) begin
          // Drop the byte but let the write in flight finish before faulting.
          ovr_d = 1'b1;
        end
      end
      StDone, StError: ;
      default: state_d = StHeader;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StHeader;
      hcnt_q      <= '0;
      for (int i = 0; i < 16; i++) hdr_q[i] <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= '0;
      mapper_q    <= '0;
      submapper_q <= '0;
      prg_q       <= '0;
      chr_q       <= '0;
      mir_q       <= 1'b0;
      four_q      <= 1'b0;
      batt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      if (hdr_we) hdr_q[hcnt_q] <= in_data_i;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      mapper_q    <= mapper_d;
      submapper_q <= submapper_d;
      prg_q       <= prg_d;
      chr_q       <= chr_d;
      mir_q       <= mir_d;
      four_q      <= four_d;
      batt_q      <= batt_d;
    end
  end

  assign in_wait_o     = wr_q | (state_q == StCheck);
  assign mem_write_o   = wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_o    = data_q;
  assign mapper_o      = mapper_q;
  assign submapper_o   = submapper_q;
  assign prg_units_o   = prg_q;
  assign chr_units_o   = chr_q;
  assign mirroring_o   = mir_q ^ invert_mirror_i;
  assign four_screen_o = four_q;
  assign battery_o     = batt_q;
  assign done_o        = (state_q == StDone);
  assign error_o       = (state_q == StError);
  assign err_code_o    = err_q;

endmodule

// File: tb/tb_ines_stream_loader.sv
// Bench for ines_stream_loader with a reduced 15-bit address space so a complete image
// (trainer + 16 KB PRG + 8 KB CHR) fits the cycle budget. A stimulus side pushes the expected
// write address/data into a scoreboard; a monitor pops and compares at each new write request.
module tb_ines_stream_loader;

  localparam int AW = 15;
  localparam int REGION = 1 << (AW - 1);
  localparam int TB_BASE = 'h7E00;
  localparam bit TR_EN = 1'b1;

  typedef logic [7:0] hdr_t [16];
  typedef struct {
    int mapper, sub, prg, chr, mir, four, batt, err;
  } hexp_t;

  logic clk = 1'b0, reset = 1'b1, invert_mirror = 1'b0;
  logic in_valid = 1'b0, mem_ack = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_wait, mem_write, done, error, mirroring, four_screen, battery;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data;
  logic [11:0] mapper, prg_units, chr_units;
  logic [3:0] submapper;
  logic [2:0] err_code;

  int checks = 0, failures = 0, writes = 0;
  int ack_delay = 0;
  bit rand_ack = 1'b0;
  int ea[$];
  logic [7:0] ed[$];
  hdr_t cur_h;
  hexp_t e;

  ines_stream_loader #(
    .ADDR_W(AW), .TRAINER_EN(TR_EN), .TRAINER_BASE(AW'(TB_BASE)), .NES20_EN(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .invert_mirror_i(invert_mirror),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_wait_o(in_wait),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_write_o(mem_write), .mem_ack_i(mem_ack),
    .mapper_o(mapper), .submapper_o(submapper), .prg_units_o(prg_units),
    .chr_units_o(chr_units), .mirroring_o(mirroring), .four_screen_o(four_screen),
    .battery_o(battery), .done_o(done), .error_o(error), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model of the header rules.
  function automatic hexp_t model_hdr(input hdr_t h);
    hexp_t m;
    bit nes2, dirty;
    nes2 = (h[7] & 8'h0C) == 8'h08;
    dirty = 1'b0;
    for (int i = 8; i < 16; i++) if (h[i] != 8'h00) dirty = 1'b1;
    if (nes2) dirty = 1'b0;
    m.mapper = (nes2 ? int'(h[8]) % 16 : 0) * 256 + (dirty ? 0 : int'(h[7]) / 16) * 16
               + int'(h[6]) / 16;
    m.sub  = nes2 ? int'(h[8]) / 16 : 0;
    m.prg  = (nes2 ? int'(h[9]) % 16 : 0) * 256 + int'(h[4]);
    m.chr  = (nes2 ? int'(h[9]) / 16 : 0) * 256 + int'(h[5]);
    m.mir  = int'(h[6]) % 2;
    m.batt = (int'(h[6]) / 2) % 2;
    m.four = (int'(h[6]) / 8) % 2;
    if (h[0] != 8'h4E || h[1] != 8'h45 || h[2] != 8'h53 || h[3] != 8'h1A) m.err = 1;
    else if (h[6][2] && !TR_EN) m.err = 2;
    else if (m.prg / 256 == 15 || m.chr / 256 == 15 || m.prg == 0) m.err = 3;
    else if (m.prg * 16384 > REGION || m.chr * 8192 > REGION) m.err = 4;
    else m.err = 0;
    return m;
  endfunction

  // Payload byte i of an image lands at: trainer tail, then PRG from 0, then CHR region.
  function automatic int exp_addr(input int i, input bit tr, input int prg_b);
    int j;
    j = i;
    if (tr) begin
      if (i < 512) return TB_BASE + i;
      j = i - 512;
    end
    if (j < prg_b) return j;
    return REGION + (j - prg_b);
  endfunction

  task automatic build_hdr(input logic [7:0] p4, p5, p6, p7, p8, p9);
    cur_h[0] = 8'h4E; cur_h[1] = 8'h45; cur_h[2] = 8'h53; cur_h[3] = 8'h1A;
    cur_h[4] = p4; cur_h[5] = p5; cur_h[6] = p6; cur_h[7] = p7; cur_h[8] = p8; cur_h[9] = p9;
    for (int i = 10; i < 16; i++) cur_h[i] = 8'h00;
  endtask

  // Called at a negedge; honours in_wait, returns one negedge after the strobe.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (in_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL in_wait_timeout got=1 exp=0");
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input int first, input int n, input bit tr, input int prg_b);
    logic [7:0] b;
    for (int i = first; i < first + n; i++) begin
      b = 8'($urandom);
      ea.push_back(exp_addr(i, tr, prg_b));
      ed.push_back(b);
      send_byte(b);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ea.delete();
    ed.delete();
  endtask

  task automatic run_header(input logic inv);
    invert_mirror = inv;
    for (int i = 0; i < 16; i++) send_byte(cur_h[i]);
    @(negedge clk);
    e = model_hdr(cur_h);
    check("hdr_done", done, 0);
    check("hdr_err_code", err_code, e.err);
    check("hdr_error", error, e.err != 0);
    if (e.err == 0) begin
      check("mapper", mapper, e.mapper);
      check("submapper", submapper, e.sub);
      check("prg_units", prg_units, e.prg);
      check("chr_units", chr_units, e.chr);
      check("mirroring", mirroring, e.mir ^ int'(inv));
      check("four_screen", four_screen, e.four);
      check("battery", battery, e.batt);
      check("hdr_in_wait", in_wait, 0);
    end
  endtask

  // Monitor: each new write request must match the head of the scoreboard.
  initial begin
    int a;
    logic [7:0] d;
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_write && !prev) begin
        writes++;
        checks++;
        if (ea.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got=%0h/%0h exp=none", mem_addr, mem_data);
        end else begin
          a = ea.pop_front();
          d = ed.pop_front();
          if (int'(mem_addr) != a || mem_data != d) begin
            failures++;
            $display("FAIL write got=%0h/%0h exp=%0h/%0h", mem_addr, mem_data, a, d);
          end
        end
      end
      prev = mem_write;
    end
  end

  // Memory side: one-cycle ack after a (possibly random) delay.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (mem_write && !reset) begin
        d = rand_ack ? (($urandom_range(0, 7) == 0) ? 2 : 0) : ack_delay;
        repeat (d) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Reset state.
    check("rst_mem_write", mem_write, 0);
    check("rst_in_wait", in_wait, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mapper", mapper, 0);
    check("rst_prg_units", prg_units, 0);
    check("rst_chr_units", chr_units, 0);
    check("rst_mirroring", mirroring, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);

    // Directed and random headers; payload strobes afterwards must not reach memory.
    for (int t = 0; t < 15; t++) begin
      case (t)
        0: begin build_hdr(1, 1, 8'h13, 8'h10, 8'h05, 8'h00); end  // iNES1 dirty
        1: begin build_hdr(1, 1, 8'h1B, 8'h18, 8'h31, 8'h00); end  // NES 2.0
        2: begin build_hdr(1, 1, 8'h10, 8'h00, 8'h00, 8'h00); cur_h[3] = 8'h00; end
        3: begin build_hdr(0, 1, 8'h00, 8'h00, 8'h00, 8'h00); end  // zero PRG
        4: begin build_hdr(1, 0, 8'h00, 8'h08, 8'h00, 8'h0F); end  // exponent form
        5: begin build_hdr(2, 0, 8'h00, 8'h00, 8'h00, 8'h00); end  // PRG overflow
        6: begin build_hdr(1, 3, 8'h00, 8'h00, 8'h00, 8'h00); end  // CHR overflow
        default: begin
          build_hdr(8'($urandom_range(0, 2)), 8'($urandom_range(0, 3)), 8'($urandom),
                    8'($urandom), $urandom_range(0, 1) ? 8'($urandom) : 8'h00, 8'($urandom));
          for (int i = 10; i < 16; i++) cur_h[i] = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
        end
      endcase
      run_header(t[0]);
      if (e.err != 0) begin
        w0 = writes;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        repeat (3) @(negedge clk);
        check("err_absorb_writes", writes - w0, 0);
        check("err_sticky", err_code, e.err);
      end
      do_reset();
    end

    // Overrun: strobe while a slow write is pending.
    build_hdr(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    run_header(1'b0);
    ack_delay = 5;
    w0 = writes;
    send_payload(0, 1, 1'b0, 16384);
    check("ovr_in_wait", in_wait, 1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!error && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ovr_error", error, 1);
    check("ovr_err_code", err_code, 5);
    check("ovr_done", done, 0);
    check("ovr_writes", writes - w0, 1);
    check("ovr_drained", ea.size(), 0);
    repeat (4) @(negedge clk);
    do_reset();
    ack_delay = 0;

    // Reset mid-PRG while a write request is held.
    build_hdr(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    run_header(1'b0);
    send_payload(0, 10, 1'b0, 16384);
    ack_delay = 3;
    send_payload(10, 1, 1'b0, 16384);
    check("mid_mem_write", mem_write, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_mem_write", mem_write, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_prg_units", prg_units, 0);
    @(negedge clk);
    reset = 1'b0;
    ea.delete();
    ed.delete();
    repeat (8) @(negedge clk);
    ack_delay = 0;

    // Fresh complete image: trainer + 16 KB PRG + 8 KB CHR, random ack latency.
    rand_ack = 1'b1;
    build_hdr(1, 1, 8'h14, 8'h00, 8'h00, 8'h00);
    run_header(1'b0);
    w0 = writes;
    send_payload(0, 512 + 16384 + 8192, 1'b1, 16384);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("img_done", done, 1);
    check("img_error", error, 0);
    check("img_err_code", err_code, 0);
    check("img_writes", writes - w0, 512 + 16384 + 8192);
    check("img_drained", ea.size(), 0);
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    check("img_absorb_writes", writes - w0, 512 + 16384 + 8192);
    check("img_done_sticky", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
